// File: rtl/activity_stretch_ctrl_if.sv
// Activity/LED bus between the MIDI port event sources, the stretch controller and the LED shifter.
interface activity_stretch_ctrl_if;
    logic [15:0] evt_in;
    logic [15:0] evt_out;
    logic [15:0] led_in;
    logic [15:0] led_out;

    modport master (output evt_in, output evt_out, input led_in, input led_out);
    modport slave  (input evt_in, input evt_out, output led_in, output led_out);
endinterface

// File: rtl/activity_stretch_ctrl.sv
// Stretches one-cycle MIDI activity pulses into visible LED on/off periods, 32 channels time-shared.
// Optional lamp test after reset is enabled by defining ACT_LAMPTEST_EN.
module activity_stretch_ctrl #(
    parameter int unsigned PRESCALE = 32'd12000,
    parameter int unsigned HOLD_MS  = 32'd40,
    parameter int unsigned GAP_MS   = 32'd20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    activity_stretch_ctrl_if.slave bus
);

    localparam int unsigned NCH        = 32'd32;
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 32'd1);
    localparam logic [7:0]  HOLD_LOAD  = 8'(HOLD_MS - 32'd1);
    localparam logic [7:0]  GAP_LOAD   = 8'(GAP_MS - 32'd1);

    typedef enum logic [1:0] {CH_IDLE = 2'd0, CH_ON = 2'd1, CH_GAP = 2'd2} ch_state_e;
    typedef enum logic {SC_WAIT = 1'b0, SC_SCAN = 1'b1} scan_state_e;

    logic [15:0] presc_r;
    logic [15:0] presc_nxt_s;
    logic        tick_s;

    scan_state_e scan_r;
    scan_state_e scan_nxt_s;
    logic [4:0]  scan_idx_r;
    logic [4:0]  idx_nxt_s;
    logic        tick_pend_r;
    logic        tpend_nxt_s;

    logic [31:0] evt_vec_s;
    logic [31:0] pend_r;
    logic [31:0] pend_nxt_s;
    logic [31:0] clr_mask_s;

    ch_state_e   ch_state_r [NCH];
    logic [7:0]  ch_cnt_r   [NCH];

    logic        svc_en_s;
    ch_state_e   svc_state_s;
    logic [7:0]  svc_cnt_s;
    logic        svc_pend_s;
    ch_state_e   svc_state_nxt_s;
    logic [7:0]  svc_cnt_nxt_s;
    logic        svc_clr_s;

    logic [31:0] on_vec_r;
    logic [31:0] on_vec_nxt_s;

    assign evt_vec_s = {bus.evt_out, bus.evt_in};

    // Millisecond prescaler; tick marks the last count before wrapping.
    always_comb begin
        tick_s = (presc_r == PRESC_LAST);
        if (tick_s) begin
            presc_nxt_s = 16'd0;
        end else begin
            presc_nxt_s = presc_r + 16'd1;
        end
    end

    // Scan sequencer next state; a tick seen mid-scan chains straight into another scan.
    always_comb begin
        scan_nxt_s  = scan_r;
        idx_nxt_s   = scan_idx_r;
        tpend_nxt_s = tick_pend_r;
        case (scan_r)
            SC_WAIT: begin
                tpend_nxt_s = 1'b0;
                idx_nxt_s   = 5'd0;
                if (tick_s) begin
                    scan_nxt_s = SC_SCAN;
                end else begin
                    scan_nxt_s = SC_WAIT;
                end
            end
            SC_SCAN: begin
                if (scan_idx_r == 5'd31) begin
                    idx_nxt_s   = 5'd0;
                    tpend_nxt_s = 1'b0;
                    if (tick_pend_r || tick_s) begin
                        scan_nxt_s = SC_SCAN;
                    end else begin
                        scan_nxt_s = SC_WAIT;
                    end
                end else begin
                    idx_nxt_s   = scan_idx_r + 5'd1;
                    tpend_nxt_s = tick_pend_r | tick_s;
                end
            end
            default: begin
                scan_nxt_s  = SC_WAIT;
                idx_nxt_s   = 5'd0;
                tpend_nxt_s = 1'b0;
            end
        endcase
    end

    // Per-channel service for the channel under the scan index.
    always_comb begin
        svc_en_s        = (scan_r == SC_SCAN);
        svc_state_s     = ch_state_r[scan_idx_r];
        svc_cnt_s       = ch_cnt_r[scan_idx_r];
        svc_pend_s      = pend_r[scan_idx_r];
        svc_state_nxt_s = svc_state_s;
        svc_cnt_nxt_s   = svc_cnt_s;
        svc_clr_s       = 1'b0;
        case (svc_state_s)
            CH_IDLE: begin
                if (svc_pend_s) begin
                    svc_state_nxt_s = CH_ON;
                    svc_cnt_nxt_s   = HOLD_LOAD;
                    svc_clr_s       = 1'b1;
                end else begin
                    svc_state_nxt_s = CH_IDLE;
                end
            end
            CH_ON: begin
                if (svc_cnt_s == 8'd0) begin
                    svc_state_nxt_s = CH_GAP;
                    svc_cnt_nxt_s   = GAP_LOAD;
                end else begin
                    svc_cnt_nxt_s   = svc_cnt_s - 8'd1;
                end
            end
            CH_GAP: begin
                if (svc_cnt_s != 8'd0) begin
                    svc_cnt_nxt_s   = svc_cnt_s - 8'd1;
                end else if (svc_pend_s) begin
                    svc_state_nxt_s = CH_ON;
                    svc_cnt_nxt_s   = HOLD_LOAD;
                    svc_clr_s       = 1'b1;
                end else begin
                    svc_state_nxt_s = CH_IDLE;
                end
            end
            default: begin
                svc_state_nxt_s = CH_IDLE;
                svc_cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // Sticky pending flags; a new pulse outranks the service clear in the same cycle.
    always_comb begin
        if (svc_en_s && svc_clr_s) begin
            clr_mask_s = 32'd1 << scan_idx_r;
        end else begin
            clr_mask_s = 32'd0;
        end
        pend_nxt_s   = (pend_r & ~clr_mask_s) | evt_vec_s;
        on_vec_nxt_s = on_vec_r;
        if (svc_en_s) begin
            on_vec_nxt_s[scan_idx_r] = (svc_state_nxt_s == CH_ON);
        end else begin
            on_vec_nxt_s = on_vec_r;
        end
    end

    // Prescaler, scan sequencer, pending flags and LED-on shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r     <= 16'd0;
            scan_r      <= SC_WAIT;
            scan_idx_r  <= 5'd0;
            tick_pend_r <= 1'b0;
            pend_r      <= 32'd0;
            on_vec_r    <= 32'd0;
        end else begin
            presc_r     <= presc_nxt_s;
            scan_r      <= scan_nxt_s;
            scan_idx_r  <= idx_nxt_s;
            tick_pend_r <= tpend_nxt_s;
            pend_r      <= pend_nxt_s;
            on_vec_r    <= on_vec_nxt_s;
        end
    end

    // Channel state/counter storage; only the serviced entry is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 32'sd0; i < NCH; i++) begin
                ch_state_r[i] <= CH_IDLE;
                ch_cnt_r[i]   <= 8'd0;
            end
        end else if (svc_en_s) begin
            ch_state_r[scan_idx_r] <= svc_state_nxt_s;
            ch_cnt_r[scan_idx_r]   <= svc_cnt_nxt_s;
        end
    end

`ifdef ACT_LAMPTEST_EN
    logic [7:0]  lamp_cnt_r;
    logic [7:0]  lamp_cnt_nxt_s;
    logic        lamp_act_r;
    logic        lamp_act_nxt_s;
    logic [31:0] led_r;
    logic [31:0] led_nxt_s;

    // Lamp test lasts 255 ticks from reset release, then the live channel view takes over.
    always_comb begin
        lamp_cnt_nxt_s = lamp_cnt_r;
        lamp_act_nxt_s = lamp_act_r;
        if (lamp_act_r && tick_s) begin
            lamp_cnt_nxt_s = lamp_cnt_r + 8'd1;
            if (lamp_cnt_r == 8'd254) begin
                lamp_act_nxt_s = 1'b0;
            end else begin
                lamp_act_nxt_s = 1'b1;
            end
        end else begin
            lamp_act_nxt_s = lamp_act_r;
        end
        if (lamp_act_nxt_s) begin
            led_nxt_s = 32'hFFFF_FFFF;
        end else begin
            led_nxt_s = on_vec_nxt_s;
        end
    end

    // Lamp-test sequencing and the output LED register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamp_cnt_r <= 8'd0;
            lamp_act_r <= 1'b1;
            led_r      <= 32'd0;
        end else begin
            lamp_cnt_r <= lamp_cnt_nxt_s;
            lamp_act_r <= lamp_act_nxt_s;
            led_r      <= led_nxt_s;
        end
    end

    assign bus.led_in  = led_r[15:0];
    assign bus.led_out = led_r[31:16];
`else
    assign bus.led_in  = on_vec_r[15:0];
    assign bus.led_out = on_vec_r[31:16];
`endif

endmodule

// File: doc/activity_stretch_ctrl.md
ACTIVITY_STRETCH_CTRL -- requirements
Module: activity_stretch_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 12000, clk cycles per millisecond tick (legal range 40..65535).
REQ-002 SHALL have parameter HOLD_MS, default 40, LED on-time in ticks (legal 1..255).
REQ-003 SHALL have parameter GAP_MS, default 20, forced off-time after each on-period in ticks (legal 1..255).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port evt_in, input, 16, one-cycle activity pulses from MIDI input ports 0..15, synchronous to clk.
REQ-007 SHALL have port evt_out, input, 16, one-cycle activity pulses from MIDI output ports 0..15.
REQ-008 SHALL have port led_in, output, 16, registered LED-on vector for input ports; feeds the LED shifter's in bus.
REQ-009 SHALL have port led_out, output, 16, registered LED-on vector for output ports; feeds the LED shifter's out bus.

Function
REQ-010 SHALL map channels 0..15 to evt_in/led_in bits 0..15 and channels 16..31 to evt_out/led_out bits 0..15.
REQ-011 SHALL keep a 32-bit sticky pending vector; an event pulse sets the channel bit that cycle; set wins over a same-cycle clear.
REQ-012 SHALL run a prescaler counting 0..PRESCALE-1, asserting an internal tick in the cycle the count equals PRESCALE-1, then wrapping to 0.
REQ-013 SHALL sequence with scan FSM WAIT -> SCAN -> WAIT: WAIT leaves on tick; SCAN services channel index 0..31, one per cycle, returning to WAIT after index 31.
REQ-014 SHALL latch a tick arriving during SCAN and start the next SCAN immediately after index 31; at most one tick outstanding, further ticks dropped.
REQ-015 SHALL hold per channel a 2-bit state (IDLE, ON, GAP) and an 8-bit down-counter; only the serviced channel changes.
REQ-016 IDLE service: pending=1 -> ON, counter=HOLD_MS-1, clear pending; else stay IDLE.
REQ-017 ON service: counter=0 -> GAP, counter=GAP_MS-1; else decrement; pending untouched.
REQ-018 GAP service: counter=0 and pending=1 -> ON, counter=HOLD_MS-1, clear pending; counter=0 and pending=0 -> IDLE; else decrement.
REQ-019 Continuous traffic SHALL therefore blink at HOLD_MS on / GAP_MS off; events during ON/GAP are merged into one pending flag.
REQ-020 led bit SHALL be 1 exactly when channel state is ON, registered, updating the cycle after the service cycle.
REQ-021 Event-to-LED latency SHALL be at most PRESCALE+33 cycles from an IDLE channel.

Reset
REQ-022 rst_n low SHALL immediately clear led_in, led_out, pending, all channel states (IDLE), counters, prescaler, scan index, latched tick, and force WAIT.
REQ-023 Reset mid-SCAN SHALL abandon the scan; after release the first scan begins on the first tick at prescaler count PRESCALE-1.

Configuration
REQ-024 With ACT_LAMPTEST_EN defined, SHALL after reset release drive led_in/led_out all-ones for 255 ticks, scan FSM and pending capture running normally underneath, then show normal state.
REQ-025 Without ACT_LAMPTEST_EN, SHALL show normal channel state from the first cycle after reset release, no lamp-test logic present.

Verification
REQ-026 PRESCALE=40, HOLD_MS=3, GAP_MS=2; evt_in[0] pulse at cycle 5 -> led_in[0] rises cycle 41, falls 3 ticks later (cycle 161), stays 0.
REQ-027 evt_out[15] held high continuously -> led_out[15] toggles 3 ticks on / 2 ticks off, period 200 cycles, no skipped period.
REQ-028 evt_in[3] pulse at cycle 40 (scan index 0 cycle) and again while ON -> exactly one extra ON period after the GAP, then IDLE.
REQ-029 All 32 event bits pulsed same cycle -> all 32 LEDs on, bit i rising at scan index i+1; none lost.
REQ-030 rst_n low for 2 cycles mid-SCAN with LEDs on -> all outputs 0 during reset; no LED until a new event.
REQ-031 ACT_LAMPTEST_EN defined, PRESCALE=40 -> outputs 0xFFFF/0xFFFF for 255 ticks after reset, then 0 absent events.
